alu_arbiter: RTL and testbench

Shares the single registered ALU between two requesters: port 0 (execute stage) and port 1 (address/branch helper). Requests use a valid/ready handshake. The block arbitrates, drives the ALU operand/op inputs, tracks the one-cycle in-flight operation, and buffers results in a 2-entry in-order FIFO. Each result returns to its originating port under a valid/ready handshake.

---
 rtl/alu_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one registered ALU between two requesters (port 0: execute stage,
//   port 1: address/branch helper). Requests are arbitrated, the winner's
//   operands drive the ALU, the one-cycle in-flight op is tracked, and results
//   are buffered in a 2-entry in-order FIFO and returned to the originating
//   port.
//
//   Build option: define ALU_ARB_RR_EN for round-robin arbitration on
//   contention; otherwise port 0 has fixed priority.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   req{0,1}_valid/_ready           request handshake
//   req{0,1}_op1/_op2/_op           request operands and ALU op code
//   rsp{0,1}_valid/_ready/_data     response handshake and result
//   alu_op1/alu_op2/alu_op          ALU inputs (zero when not issuing)
//   alu_out                         ALU registered result, one cycle after issue
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic [OP_W-1:0]   req0_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out
);

  logic              vld_p1;
  logic              id_p1;
  logic [DATA_W-1:0] fifo_data [2];
  logic              fifo_id   [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_cnt;
  logic              head_id;
  logic              push;
  logic              pop;
  logic [1:0]        cnt_after_pop;
  logic              can_issue;
  logic              grant;
  logic              issue;
`ifdef ALU_ARB_RR_EN
  logic              last_grant;
`endif

  // ---- stage p0: arbitration and ALU drive ----
  always_comb begin
    head_id    = fifo_id[rd_ptr];
    rsp0_valid = (fifo_cnt != 2'd0) && !head_id;
    rsp1_valid = (fifo_cnt != 2'd0) && head_id;
    rsp0_data  = fifo_data[rd_ptr];
    rsp1_data  = fifo_data[rd_ptr];
    pop        = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
    push       = vld_p1;

    // Only issue when a FIFO slot is guaranteed free on landing, so the
    // registered ALU result never has to be held.
    cnt_after_pop = fifo_cnt - {1'b0, pop};
    can_issue     = !rst && ((cnt_after_pop + {1'b0, vld_p1}) <= 2'd1);

    grant = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
      grant = ~last_grant;
`else
      grant = 1'b0;
`endif
    end else if (req1_valid) begin
      grant = 1'b1;
    end

    issue      = can_issue && (req0_valid || req1_valid);
    req0_ready = can_issue && !grant;
    req1_ready = can_issue && grant;

    alu_op1 = '0;
    alu_op2 = '0;
    alu_op  = '0;
    if (issue) begin
      alu_op1 = grant ? req1_op1 : req0_op1;
      alu_op2 = grant ? req1_op2 : req0_op2;
      alu_op  = grant ? req1_op  : req0_op;
    end
  end

  // ---- stage p1: in-flight tracking and FIFO control ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      fifo_cnt <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      vld_p1   <= issue;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
`ifdef ALU_ARB_RR_EN
      if (issue) last_grant <= grant;
`endif
    end
  end

  // ---- stage p2: result storage (data path, not reset) ----
  always_ff @(posedge clk) begin
    if (issue) id_p1 <= grant;
    if (push) begin
      fifo_data[wr_ptr] <= alu_out;
      fifo_id[wr_ptr]   <= id_p1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed steps plus a scoreboard of
// expected {port, result} entries pushed at request fire and popped at
// response fire. The bench also plays the role of the registered ALU.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [4:0]  req0_op, req1_op, alu_op;
  logic [31:0] rsp0_data, rsp1_data, alu_op1, alu_op2, alu_out;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] sb [$];
  int          glog [$];
  logic [32:0] mon_e0, mon_e1;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_op(req0_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_op(req1_op),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op(alu_op), .alu_out(alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      5'b01101: alu_f = a + b;
      5'b01110: alu_f = a - b;
      5'b00110: alu_f = a ^ b;
      default:  alu_f = a & b;
    endcase
  endfunction

  always @(posedge clk) alu_out <= alu_f(alu_op, alu_op1, alu_op2);

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor; inputs only change just after posedge, so the values
  // seen at negedge are the ones the DUT samples at the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (req0_valid && req0_ready) begin
        sb.push_back({1'b0, alu_f(req0_op, req0_op1, req0_op2)});
        glog.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        sb.push_back({1'b1, alu_f(req1_op, req1_op1, req1_op2)});
        glog.push_back(1);
      end
      if (rsp0_valid && rsp0_ready) begin
        if (sb.size() == 0) chk("unexpected_rsp0", 1, 0);
        else begin
          mon_e0 = sb.pop_front();
          chk("rsp0_port", 0, mon_e0[32]);
          chk("rsp0_data", rsp0_data, mon_e0[31:0]);
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (sb.size() == 0) chk("unexpected_rsp1", 1, 0);
        else begin
          mon_e1 = sb.pop_front();
          chk("rsp1_port", 1, mon_e1[32]);
          chk("rsp1_data", rsp1_data, mon_e1[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    sb.delete();
    glog.delete();
    rst = 1'b0;
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic set0(logic v, logic [4:0] op, logic [31:0] a, logic [31:0] b);
    req0_valid = v; req0_op = op; req0_op1 = a; req0_op2 = b;
  endtask

  task automatic set1(logic v, logic [4:0] op, logic [31:0] a, logic [31:0] b);
    req1_valid = v; req1_op = op; req1_op1 = a; req1_op2 = b;
  endtask

  initial begin
    int i0, i1, cyc;
    int exp_g [8];
    rst = 1'b1;
    set0(1'b0, 5'd0, 32'd0, 32'd0);
    set1(1'b0, 5'd0, 32'd0, 32'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    // Reset state
    tick();
    tick();
    sample();
    chk("reset_req0_ready", req0_ready, 0);
    chk("reset_req1_ready", req1_ready, 0);
    chk("reset_rsp0_valid", rsp0_valid, 0);
    chk("reset_rsp1_valid", rsp1_valid, 0);
    chk("reset_alu_op", alu_op, 0);

    // Single op: add 5+7
    tick();
    rst = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set0(1'b1, 5'b01101, 32'd5, 32'd7);
    sample();
    chk("single_req0_ready", req0_ready, 1);
    chk("single_req1_ready", req1_ready, 0);
    chk("single_alu_op", alu_op, 5'b01101);
    chk("single_alu_op1", alu_op1, 5);
    chk("single_alu_op2", alu_op2, 7);
    tick();
    req0_valid = 1'b0;
    sample();
    chk("single_n1_rsp0_valid", rsp0_valid, 0);
    chk("single_idle_alu_op", alu_op, 0);
    tick();
    sample();
    chk("single_rsp0_valid", rsp0_valid, 1);
    chk("single_rsp0_data", rsp0_data, 12);
    chk("single_rsp1_valid", rsp1_valid, 0);
    tick();
    sample();
    chk("single_after_rsp0_valid", rsp0_valid, 0);

    // Back-to-back: sub then xor
    tick();
    set0(1'b1, 5'b01110, 32'd10, 32'd3);
    sample();
    chk("b2b_ready_a", req0_ready, 1);
    tick();
    set0(1'b1, 5'b00110, 32'hF0, 32'hFF);
    sample();
    chk("b2b_ready_b", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    sample();
    chk("b2b_rsp_a_valid", rsp0_valid, 1);
    chk("b2b_rsp_a_data", rsp0_data, 7);
    tick();
    sample();
    chk("b2b_rsp_b_valid", rsp0_valid, 1);
    chk("b2b_rsp_b_data", rsp0_data, 32'h0F);
    tick();
    sample();
    chk("b2b_after_valid", rsp0_valid, 0);
    tick();

    // Contention: both ports hold 4 requests each
    do_reset();
    i0 = 0;
    i1 = 0;
    cyc = 0;
    while ((i0 < 4 || i1 < 4) && cyc < 60) begin
      set0(i0 < 4, 5'b01101, 32'(100 + i0), 32'd1);
      set1(i1 < 4, 5'b00110, 32'(200 + i1), 32'h55);
      sample();
      if (req0_valid && req0_ready) i0++;
      if (req1_valid && req1_ready) i1++;
      tick();
      cyc++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("cont_all_issued", (i0 == 4 && i1 == 4), 1);
    drain("cont_drain");
`ifdef ALU_ARB_RR_EN
    exp_g = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    chk("cont_grant_count", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++)
      chk($sformatf("cont_grant%0d", i), glog[i], exp_g[i]);

    // Backpressure: three port-0 ops with rsp0_ready low
    rsp0_ready = 1'b0;
    set0(1'b1, 5'b01101, 32'd1, 32'd1);
    sample();
    chk("bp_issue_a", req0_ready, 1);
    tick();
    set0(1'b1, 5'b01101, 32'd2, 32'd2);
    sample();
    chk("bp_issue_b", req0_ready, 1);
    tick();
    set0(1'b1, 5'b01101, 32'd3, 32'd3);
    sample();
    chk("bp_stall_a", req0_ready, 0);
    chk("bp_head_valid", rsp0_valid, 1);
    tick();
    sample();
    chk("bp_stall_b", req0_ready, 0);
    tick();
    sample();
    chk("bp_stall_c", req0_ready, 0);
    tick();
    rsp0_ready = 1'b1;
    sample();
    chk("bp_release_issue", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    drain("bp_drain");

    // Head-of-line blocking
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    set0(1'b1, 5'b01101, 32'd7, 32'd8);
    sample();
    chk("hol_issue0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    set1(1'b1, 5'b00110, 32'd3, 32'd5);
    sample();
    chk("hol_issue1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    sample();
    chk("hol_rsp0_valid", rsp0_valid, 1);
    chk("hol_rsp1_blocked_a", rsp1_valid, 0);
    tick();
    sample();
    chk("hol_rsp1_blocked_b", rsp1_valid, 0);
    tick();
    rsp0_ready = 1'b1;
    sample();
    chk("hol_rsp1_blocked_c", rsp1_valid, 0);
    tick();
    sample();
    chk("hol_rsp1_valid", rsp1_valid, 1);
    chk("hol_rsp1_data", rsp1_data, 6);
    tick();
    drain("hol_drain");

    // Reset mid-flight
    set0(1'b1, 5'b01101, 32'd9, 32'd9);
    sample();
    chk("rmf_issue", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    sample();
    chk("rmf_ready_in_rst", req0_ready, 0);
    tick();
    rst = 1'b0;
    sb.delete();
    for (int k = 0; k < 4; k++) begin
      sample();
      chk($sformatf("rmf_rsp0_quiet%0d", k), rsp0_valid, 0);
      chk($sformatf("rmf_rsp1_quiet%0d", k), rsp1_valid, 0);
      tick();
    end
    set0(1'b1, 5'b01101, 32'd20, 32'd22);
    sample();
    chk("rmf2_ready", req0_ready, 1);
    chk("rmf2_alu_op", alu_op, 5'b01101);
    tick();
    req0_valid = 1'b0;
    sample();
    chk("rmf2_n1_rsp0_valid", rsp0_valid, 0);
    tick();
    sample();
    chk("rmf2_rsp0_valid", rsp0_valid, 1);
    chk("rmf2_rsp0_data", rsp0_data, 42);
    tick();
    drain("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
